iter_muldiv: RTL and testbench

ITER_MULDIV -- requirements
Module: iter_muldiv

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_negate.sv | 14 +
 rtl/iter_muldiv.sv | 186 ++++++++++++++++++
 tb/tb_iter_muldiv.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes (RISC-V funct3 order),
// FSM state codes, the default operand width and small op-decoding helpers.
package muldiv_pkg;

  localparam int MULDIV_WIDTH_DEF = 32;

  typedef logic [2:0] muldiv_op_t;

  localparam muldiv_op_t OP_MUL    = 3'd0;
  localparam muldiv_op_t OP_MULH   = 3'd1;
  localparam muldiv_op_t OP_MULHSU = 3'd2;
  localparam muldiv_op_t OP_MULHU  = 3'd3;
  localparam muldiv_op_t OP_DIV    = 3'd4;
  localparam muldiv_op_t OP_DIVU   = 3'd5;
  localparam muldiv_op_t OP_REM    = 3'd6;
  localparam muldiv_op_t OP_REMU   = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic op_is_mul(input muldiv_op_t op);
    return ~op[2];
  endfunction

  function automatic logic op_a_signed(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's complement: dout = neg ? -din : din.
module muldiv_negate
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH_DEF
) (
  input  logic [WIDTH-1:0] din,
  input  logic             neg,
  output logic [WIDTH-1:0] dout
);

  assign dout = neg ? (~din + WIDTH'(1)) : din;

endmodule

// File: rtl/iter_muldiv.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide, one bit per cycle.
// Optional macro ITER_MULDIV_EARLY_OUT_EN: zero-operand requests bypass CALC/FIX straight to DONE.
//
// state   | meaning
// IDLE    | waiting for a request, in_ready high
// CALC    | WIDTH iterations on operand magnitudes
// FIX     | sign correction and result select
// DONE    | result held on out_valid until out_ready
module iter_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MULDIV_WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             dz_q, dz_d;

  logic             accept;
  logic             in_mul, in_sa, in_sb;
  logic [WIDTH-1:0] a_mag, b_mag;

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = res_q;
  assign accept    = in_valid & in_ready & ~flush;

  assign in_mul = op_is_mul(op);
  assign in_sa  = op_a_signed(op) & in_a[WIDTH-1];
  assign in_sb  = op_b_signed(op) & in_b[WIDTH-1];

  muldiv_negate #(.WIDTH(WIDTH)) u_neg_a (.din(in_a), .neg(in_sa), .dout(a_mag));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_b (.din(in_b), .neg(in_sb), .dout(b_mag));

  logic             early_hit;
  logic [WIDTH-1:0] early_res;

`ifdef ITER_MULDIV_EARLY_OUT_EN
  assign early_hit = (in_b == '0) | (in_mul & (in_a == '0));
`else
  assign early_hit = 1'b0;
`endif

  // Early results: any product with a zero operand is 0; otherwise it is a divide by zero.
  always_comb begin
    early_res = '0;
    if (!in_mul) begin
      if ((op == OP_DIV) || (op == OP_DIVU)) early_res = '1;
      else                                   early_res = in_a;
    end
  end

  logic [WIDTH:0] sum, shifted, diff;

  assign sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign shifted = {hi_q, lo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, b_q};

  logic             is_mul_q, res_neg;
  logic [WIDTH-1:0] lo_fix, hi_neg, hi_fix;

  assign is_mul_q = op_is_mul(op_q);
  assign res_neg  = sa_q ^ sb_q;

  // Negating the 2W-bit product per half: the high half only takes the +1 carry when lo is 0.
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_lo (.din(lo_q), .neg(res_neg), .dout(lo_fix));
  muldiv_negate #(.WIDTH(WIDTH)) u_neg_hi (
    .din (hi_q),
    .neg (is_mul_q ? (res_neg & (lo_q == '0)) : sa_q),
    .dout(hi_neg)
  );
  assign hi_fix = (is_mul_q & res_neg & (lo_q != '0)) ? ~hi_q : hi_neg;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    res_d   = res_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d  = op;
          a_d   = in_a;
          b_d   = b_mag;
          hi_d  = '0;
          lo_d  = a_mag;
          sa_d  = in_sa;
          sb_d  = in_sb;
          dz_d  = (in_b == '0);
          cnt_d = CNT_W'(WIDTH - 1);
          if (early_hit) begin
            res_d   = early_res;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (is_mul_q) begin
          hi_d = sum[WIDTH:1];
          lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
          hi_d = diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = shifted[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_FIX: begin
        case (op_q)
          OP_MUL:                       res_d = lo_fix;
          OP_MULH, OP_MULHSU, OP_MULHU: res_d = hi_fix;
          OP_DIV, OP_DIVU:              res_d = dz_q ? '1 : lo_fix;
          default:                      res_d = dz_q ? a_q : hi_fix;
        endcase
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      res_q   <= res_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
    end
  end

endmodule

// File: tb/tb_iter_muldiv.sv
// Self-checking bench for iter_muldiv (WIDTH=32): queue scoreboard fed at request time,
// drained by an output monitor; latency, backpressure, flush and reset scenarios.
module tb_iter_muldiv;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef ITER_MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         flush = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;

  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  string        tag_q[$];

  always #5 clk = ~clk;

  iter_muldiv #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .in_a     (in_a),
    .in_b     (in_b),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    ia = a;
    ib = b;
    case (o)
      OP_MUL:    begin p = ua * ub; return p[31:0];  end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * ub; return p[63:32]; end
      OP_MULHU:  begin p = ua * ub; return p[63:32]; end
      OP_DIV: begin
        if (b == 0) return '1;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return W'(ia / ib);
      end
      OP_DIVU:   return (b == 0) ? '1 : a / b;
      OP_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return '0;
        return W'(ia % ib);
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_for(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    if (EARLY && ((b == 0) || (!o[2] && a == 0))) return 1;
    return W + 2;
  endfunction

  // Result monitor: every handshake pops one expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_out_valid", out_valid, 1'b0);
      else                   chk(tag_q.pop_front(), result, exp_q.pop_front());
    end
  end

  task automatic launch(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string tag, input bit track);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_ready"}, in_ready, 1'b1);
    in_valid = 1'b1;
    op = o;
    in_a = a;
    in_b = b;
    if (track) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom);
    in_a = $urandom;
    in_b = $urandom;
  endtask

  task automatic wait_result(input int exp_lat, input string tag);
    int lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 200);
    chk({tag, "_lat"}, lat, exp_lat);
    @(posedge clk); #1;
  endtask

  task automatic do_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp, input string tag);
    out_ready = 1'b1;
    launch(o, a, b, exp, tag, 1'b1);
    wait_result(lat_for(o, a, b), tag);
  endtask

  initial begin
    logic [W-1:0] held, ra, rb;
    logic [2:0]   ro;
    int n;

    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff");
    do_op(OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "mul_ff");
    do_op(OP_MULH,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ff");
    do_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff");
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
    do_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
    do_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");
    do_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_z");
    do_op(OP_REMU, 32'd5, 32'd0, 32'd5, "remu_z");
    do_op(OP_DIV,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, "div_z_neg");
    do_op(OP_REM,  32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, "rem_z_neg");
    do_op(OP_MULH, 32'd0, 32'h8000_0001, 32'd0, "mulh_a0");

    for (int i = 0; i < 14; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      rb = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
      if (i % 3 == 1) rb = W'($urandom_range(1, 300));
      do_op(ro, ra, rb, model(ro, ra, rb), $sformatf("rand%0d_op%0d", i, ro));
    end

    // Backpressure with a competing request held through the handshake.
    out_ready = 1'b0;
    launch(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, model(OP_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), "bp", 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    chk("bp_lat", n, W + 2);
    held = result;
    in_valid = 1'b1;
    op = OP_MUL;
    in_a = 32'd3;
    in_b = 32'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_result", result, held);
      chk("bp_hold_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", in_ready, 1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);
    exp_q.push_back(32'd15);
    tag_q.push_back("bp_next");
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat_for(OP_MUL, 32'd3, 32'd5), "bp_next");

    // Flush during CALC cycle 10, with a simultaneous request that must not be taken.
    launch(OP_DIVU, 32'd100, 32'd7, '0, "flush_victim", 1'b0);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    in_valid = 1'b1;
    op = OP_REMU;
    in_a = 32'd100;
    in_b = 32'd7;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_idle", in_ready, 1'b1);
    chk("flush_out_valid", out_valid, 1'b0);
    exp_q.push_back(32'd2);
    tag_q.push_back("flush_b2b");
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(W + 2, "flush_b2b");

    // Asynchronous reset in the middle of CALC.
    launch(OP_MULH, 32'h7654_3210, 32'h0F0F_0F0F, '0, "rst_victim", 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_result", result, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, "post_rst_div");
    do_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, "post_rst_rem");

    chk("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
